// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM generator with a linear 1-LSB-per-tick colour fade toward a handshaked target.
// Latency: pwm_x is registered, one cycle after cnt; a new target starts fading within STEP_DIV PWM periods.
// Backpressure: tgt_ready is low for the whole fade; optional gamma curve via RGB_PWM_FADER_GAMMA_EN.
module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      halt,
    input  logic                      tgt_valid,
    output logic                      tgt_ready,
    input  logic [PWM_BITS-1:0]       tgt_r,
    input  logic [PWM_BITS-1:0]       tgt_g,
    input  logic [PWM_BITS-1:0]       tgt_b,
    output logic                      pwm_r,
    output logic                      pwm_g,
    output logic                      pwm_b,
    output logic                      busy,
    output logic [3*PWM_BITS-1:0]     cur_rgb
);

    localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
    localparam logic [15:0]         STEP_LAST = 16'(STEP_DIV - 1);

    typedef enum logic {IDLE, FADE} state_t;

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] cnt;
    logic [15:0]         step_cnt;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic [PWM_BITS-1:0] tgt_r_q, tgt_g_q, tgt_b_q;
    logic [PWM_BITS-1:0] eff_r, eff_g, eff_b;
    logic                wrap, fade_tick, accept, same_as_cur, at_tgt;

    assign wrap        = !halt && (cnt == CNT_MAX);
    assign fade_tick   = wrap && (step_cnt == STEP_LAST);
    assign accept      = tgt_valid && (state == IDLE);
    assign same_as_cur = (tgt_r == duty_r) && (tgt_g == duty_g) && (tgt_b == duty_b);
    assign at_tgt      = (duty_r == tgt_r_q) && (duty_g == tgt_g_q) && (duty_b == tgt_b_q);

    assign tgt_ready = (state == IDLE);
    assign busy      = (state == FADE);
    assign cur_rgb   = {duty_r, duty_g, duty_b};

    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] d,
                                                        input logic [PWM_BITS-1:0] t);
        if (d < t)
            return d + 1'b1;
        else if (d > t)
            return d - 1'b1;
        else
            return d;
    endfunction

`ifdef RGB_PWM_FADER_GAMMA_EN
    localparam int W2 = 2 * PWM_BITS;

    // (d*d + d) >> PWM_BITS maps full scale onto itself and keeps 1 LSB dark.
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
        logic [W2-1:0] sq;
        sq = W2'(d) * W2'(d) + W2'(d);
        return sq[W2-1:PWM_BITS];
    endfunction

    assign eff_r = gamma(duty_r);
    assign eff_g = gamma(duty_g);
    assign eff_b = gamma(duty_b);
`else
    assign eff_r = duty_r;
    assign eff_g = duty_g;
    assign eff_b = duty_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            step_cnt <= '0;
        end else if (!halt) begin
            cnt <= cnt + 1'b1;
            if (wrap)
                step_cnt <= (step_cnt == STEP_LAST) ? 16'd0 : step_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r <= 1'b0;
            pwm_g <= 1'b0;
            pwm_b <= 1'b0;
        end else if (!halt) begin
            pwm_r <= (cnt < eff_r);
            pwm_g <= (cnt < eff_g);
            pwm_b <= (cnt < eff_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r_q <= '0;
            tgt_g_q <= '0;
            tgt_b_q <= '0;
        end else if (accept) begin
            tgt_r_q <= tgt_r;
            tgt_g_q <= tgt_g;
            tgt_b_q <= tgt_b;
        end
    end

    // Duties only move on a wrap cycle, so each PWM period sees a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else if (fade_tick && (state == FADE)) begin
            duty_r <= step_toward(duty_r, tgt_r_q);
            duty_g <= step_toward(duty_g, tgt_g_q);
            duty_b <= step_toward(duty_b, tgt_b_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !same_as_cur) state_nxt = FADE;
            FADE: if (!halt && at_tgt)        state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: one instance with STEP_DIV=4 for fade/halt/handshake,
// one with STEP_DIV=1 for the static duty waveform check; both share clock and reset.
module tb_rgb_pwm_fader;

`ifdef RGB_PWM_FADER_GAMMA_EN
    localparam int R64_HIGH = 16;   // (64*64+64)>>8
    localparam int D10_HIGH = 0;    // (10*10+10)>>8
`else
    localparam int R64_HIGH = 64;
    localparam int D10_HIGH = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        halt4, tgt_valid4, tgt_ready4, pwm_r4, pwm_g4, pwm_b4, busy4;
    logic [7:0]  tgt_r4, tgt_g4, tgt_b4;
    logic [23:0] cur_rgb4;
    logic        halt1, tgt_valid1, tgt_ready1, pwm_r1, pwm_g1, pwm_b1, busy1;
    logic [7:0]  tgt_r1, tgt_g1, tgt_b1;
    logic [23:0] cur_rgb1;

    rgb_pwm_fader #(.PWM_BITS(8), .STEP_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .halt(halt4),
        .tgt_valid(tgt_valid4), .tgt_ready(tgt_ready4),
        .tgt_r(tgt_r4), .tgt_g(tgt_g4), .tgt_b(tgt_b4),
        .pwm_r(pwm_r4), .pwm_g(pwm_g4), .pwm_b(pwm_b4),
        .busy(busy4), .cur_rgb(cur_rgb4)
    );

    rgb_pwm_fader #(.PWM_BITS(8), .STEP_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .halt(halt1),
        .tgt_valid(tgt_valid1), .tgt_ready(tgt_ready1),
        .tgt_r(tgt_r1), .tgt_g(tgt_g1), .tgt_b(tgt_b1),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1),
        .busy(busy1), .cur_rgb(cur_rgb1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic send4(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        check("accept_ready", 32'(tgt_ready4), 32'd1);
        tgt_valid4 = 1'b1;
        tgt_r4 = r; tgt_g4 = g; tgt_b4 = b;
        @(negedge clk);
        tgt_valid4 = 1'b0;
    endtask

    task automatic wait_idle4(input int limit, input string tag);
        int k;
        k = 0;
        while (busy4 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy4), 32'd0);
    endtask

    initial begin
        int n_chg, last_chg, bad_rdy, frozen_bad, busy_seen, t1, hr, hg, hb, first_r, first_b, k;
        bit done;
        logic [7:0]  prev_r;
        logic [23:0] prev_rgb, snap_cur;
        logic [7:0]  snap_cnt;
        logic [2:0]  snap_pwm;

        rst_n = 1'b0;
        halt4 = 1'b0; tgt_valid4 = 1'b0; tgt_r4 = '0; tgt_g4 = '0; tgt_b4 = '0;
        halt1 = 1'b0; tgt_valid1 = 1'b0; tgt_r1 = '0; tgt_g1 = '0; tgt_b1 = '0;
        #1;
        check("rst_pwm", 32'({pwm_r4, pwm_g4, pwm_b4}), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_ready", 32'(tgt_ready4), 32'd1);
        check("rst_cur", 32'(cur_rgb4), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Long STEP_DIV=1 fade runs in the background while the STEP_DIV=4 instance is exercised.
        check("dut1_ready", 32'(tgt_ready1), 32'd1);
        tgt_valid1 = 1'b1; tgt_r1 = 8'd64; tgt_g1 = 8'd0; tgt_b1 = 8'd255;
        @(negedge clk);
        tgt_valid1 = 1'b0;

        // Fade timing: 0 -> r=3, one step every 1024 cycles, landing just after cnt wraps.
        send4(8'd3, 8'd0, 8'd0);
        check("fade_busy_start", 32'(busy4), 32'd1);
        check("fade_ready_start", 32'(tgt_ready4), 32'd0);
        n_chg = 0; last_chg = 0; bad_rdy = 0; done = 1'b0; prev_r = 8'd0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (tgt_ready4) bad_rdy++;
            if (cur_rgb4[23:16] != prev_r) begin
                n_chg++;
                check("fade_step", 32'(cur_rgb4[23:16]), 32'(prev_r) + 32'd1);
                check("fade_cnt_at_step", 32'(u_dut.cnt), 32'd0);
                if (n_chg > 1) check("fade_interval", 32'(cyc - last_chg), 32'd1024);
                last_chg = cyc;
                prev_r = cur_rgb4[23:16];
                if (prev_r == 8'd3) begin
                    check("fade_busy_at_final", 32'(busy4), 32'd1);
                    @(negedge clk);
                    check("fade_busy_drop", 32'(busy4), 32'd0);
                    check("fade_ready_back", 32'(tgt_ready4), 32'd1);
                    done = 1'b1;
                end
            end
        end
        check("fade_done", 32'(done), 32'd1);
        check("fade_steps", 32'(n_chg), 32'd3);
        check("fade_ready_low", 32'(bad_rdy), 32'd0);
        check("fade_gb_hold", 32'(cur_rgb4[15:0]), 32'd0);

        // Bring to (10,10,10) and check a PWM period at duty 10.
        send4(8'd10, 8'd10, 8'd10);
        wait_idle4(14000, "to10_idle");
        check("to10_cur", 32'(cur_rgb4), 32'h0a0a0a);
        hr = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_r4) hr++;
        end
        check("d10_high_count", 32'(hr), 32'(D10_HIGH));

        // Bidirectional fade with a 1000-cycle halt between the two ticks.
        send4(8'd8, 8'd12, 8'd10);
        n_chg = 0; t1 = 0; frozen_bad = 0;
        prev_rgb = cur_rgb4;
        for (int i = 0; i < 8000 && n_chg < 2; i++) begin
            @(negedge clk);
            if (cur_rgb4 != prev_rgb) begin
                n_chg++;
                check("bidir_r_down", 32'(cur_rgb4[23:16]), 32'(prev_rgb[23:16]) - 32'd1);
                check("bidir_g_up", 32'(cur_rgb4[15:8]), 32'(prev_rgb[15:8]) + 32'd1);
                check("bidir_b_hold", 32'(cur_rgb4[7:0]), 32'd10);
                prev_rgb = cur_rgb4;
                if (n_chg == 1) begin
                    t1 = cyc;
                    repeat (100) @(negedge clk);
                    snap_cnt = u_dut.cnt;
                    snap_cur = cur_rgb4;
                    snap_pwm = {pwm_r4, pwm_g4, pwm_b4};
                    halt4 = 1'b1;
                    repeat (1000) begin
                        @(negedge clk);
                        if (u_dut.cnt != snap_cnt || cur_rgb4 != snap_cur ||
                            {pwm_r4, pwm_g4, pwm_b4} != snap_pwm) frozen_bad++;
                    end
                    halt4 = 1'b0;
                    check("halt_frozen", 32'(frozen_bad), 32'd0);
                    check("halt_busy_held", 32'(busy4), 32'd1);
                end else begin
                    check("halt_resume_interval", 32'(cyc - t1), 32'd2024);
                end
            end
        end
        check("bidir_ticks", 32'(n_chg), 32'd2);
        check("bidir_cur", 32'(cur_rgb4), 32'h080c0a);
        wait_idle4(2, "bidir_idle");

        // Same target again: accepted, no fade.
        send4(8'd8, 8'd12, 8'd10);
        busy_seen = 0;
        repeat (600) begin
            if (busy4) busy_seen++;
            @(negedge clk);
        end
        check("noop_busy_never", 32'(busy_seen), 32'd0);
        check("noop_ready", 32'(tgt_ready4), 32'd1);
        check("noop_cur", 32'(cur_rgb4), 32'h080c0a);

        // Static waveform on the STEP_DIV=1 instance.
        k = 0;
        while (busy1 && k < 70000) begin
            @(negedge clk);
            k++;
        end
        check("static_idle", 32'(busy1), 32'd0);
        check("static_cur", 32'(cur_rgb1), 32'h4000ff);
        k = 0;
        while (u_dut1.cnt != 8'd0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("static_sync", 32'(u_dut1.cnt), 32'd0);
        hr = 0; hg = 0; hb = 0; first_r = -1; first_b = -1;
        for (int j = 0; j < 256; j++) begin
            if (pwm_r1) begin hr++; if (first_r < 0) first_r = j; end
            if (pwm_g1) hg++;
            if (pwm_b1) begin hb++; if (first_b < 0) first_b = j; end
            @(negedge clk);
        end
        check("static_r_count", 32'(hr), 32'(R64_HIGH));
        check("static_g_count", 32'(hg), 32'd0);
        check("static_b_count", 32'(hb), 32'd255);
        check("static_r_align", 32'(first_r), 32'd1);
        check("static_b_align", 32'(first_b), 32'd1);

        // Asynchronous reset mid-fade, sampled between clock edges.
        send4(8'd0, 8'd0, 8'd0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm4", 32'({pwm_r4, pwm_g4, pwm_b4}), 32'd0);
        check("arst_busy4", 32'(busy4), 32'd0);
        check("arst_ready4", 32'(tgt_ready4), 32'd1);
        check("arst_cur4", 32'(cur_rgb4), 32'd0);
        check("arst_pwm1", 32'({pwm_r1, pwm_g1, pwm_b1}), 32'd0);
        check("arst_cur1", 32'(cur_rgb1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Three-channel PWM generator with linear colour fading.
- Produces the per-channel PWM enables for the on-chip RGB LED current driver (SB_RGBA_DRV RGB0PWM/RGB1PWM/RGB2PWM). It replaces the ad-hoc divider-bit ANDing.
- Accepts a target colour over a valid/ready handshake and ramps each channel's duty by 1 LSB per fade tick until all three channels reach the target.
- Runs on the 48 MHz SB_HFOSC clock.

Parameters:
- PWM_BITS, 8: duty/counter width; PWM period = 2^PWM_BITS cycles (256 cycles = 187.5 kHz at 48 MHz).
- STEP_DIV, 4: number of PWM periods per fade tick; legal range 1..65535.

Ports:
- clk  in  1  system clock, the 48 MHz SB_HFOSC CLKHF output.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  freeze: when 1, PWM counter, step counter and fade progress hold.
- tgt_valid  in  1  target colour valid.
- tgt_ready  out  1  block can accept a target.
- tgt_r  in  PWM_BITS  target red duty.
- tgt_g  in  PWM_BITS  target green duty.
- tgt_b  in  PWM_BITS  target blue duty.
- pwm_r  out  1  red PWM; connects to RGB0PWM.
- pwm_g  out  1  green PWM; connects to RGB1PWM.
- pwm_b  out  1  blue PWM; connects to RGB2PWM.
- busy  out  1  fade in progress.
- cur_rgb  out  3*PWM_BITS  current duties, packed {r,g,b}.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, step_cnt=0, state=IDLE.
  - Duty registers duty_r/g/b=0; target registers=0.
  - pwm_r/g/b=0, busy=0, tgt_ready=1, cur_rgb=0.
- Reset mid-fade aborts immediately; outputs return to the reset values above.
- PWM counter cnt (PWM_BITS):
  - Increments every cycle with halt=0.
  - Wraps from 2^PWM_BITS-1 to 0.
  - A "wrap cycle" is a cycle with cnt==2^PWM_BITS-1 and halt=0.
- PWM output:
  - pwm_x is registered: pwm_x <= (cnt < eff_duty_x). One cycle latency from cnt to pin.
  - Duty 0 gives constant low. Duty 2^PWM_BITS-1 gives high for 255 of 256 cycles. A 100% duty is not possible, by design.
- Glitch-free: duty_x changes only on a wrap cycle, so every period uses a single duty value.
- step_cnt (16 bit):
  - Increments on each wrap cycle; wraps from STEP_DIV-1 to 0.
  - fade_tick = wrap cycle AND step_cnt==STEP_DIV-1.
- State machine, IDLE / FADE:
  - tgt_ready = (state==IDLE); busy = (state==FADE).
  - IDLE: on tgt_valid&&tgt_ready, latch tgt_r/g/b. If the latched target equals the current duties on all three channels, stay IDLE; otherwise go FADE the next cycle. step_cnt is not reset on accept, so the first tick latency ranges from 1 to STEP_DIV periods.
  - FADE: on each fade_tick, every channel with duty_x != target_x moves 1 toward the target (+1 or -1, never overshoots). A channel already at its target holds.
  - FADE to IDLE: on the cycle after the tick on which all three duties equal the target.
  - In FADE, tgt_valid is ignored (ready=0). The upstream must hold its data.
- halt=1:
  - cnt, step_cnt, duty and pwm_x registers hold their values.
  - The handshake in IDLE still accepts.
  - FADE does not advance.
- Arithmetic is unsigned. Duties never go below 0 or above 2^PWM_BITS-1.
- cur_rgb reflects duty_x (pre-gamma).

Optional Feature:
- Macro: RGB_PWM_FADER_GAMMA_EN.
- Defined: eff_duty_x = (duty_x*duty_x + duty_x) >> PWM_BITS. This uses a 2*PWM_BITS-bit intermediate, is computed combinationally from the registers, and gives a perceptually linear fade.
  - At PWM_BITS=8: duty 0 -> 0, 1 -> 0, 16 -> 1, 128 -> 64, 255 -> 255.
- Undefined: eff_duty_x = duty_x. No multiplier is inferred.

Test Plan:
- Reset: assert rst_n=0 mid-run -> pwm_r/g/b=0, busy=0, tgt_ready=1, cur_rgb=0 without waiting for a clk edge.
- Static duty: load (r=64, g=0, b=255) with STEP_DIV=1, wait until busy=0 -> per 256-cycle period pwm_r high exactly 64 cycles, pwm_g never high, pwm_b high 255 cycles, each edge-aligned one cycle after cnt==0.
- Fade timing: from 0, load r=3, STEP_DIV=4 -> duty_r steps 0->1->2->3, changing only on wrap cycles, 4 periods (1024 cycles) apart. busy drops 1 cycle after duty_r reaches 3; tgt_ready is 0 throughout the fade.
- Bidirectional / no-op: from (10,10,10), load (8,12,10) -> r falls, g rises, b constant, done after 2 ticks. Then load (8,12,10) again -> stays IDLE, busy never asserts.
- Halt: assert halt for 1000 cycles mid-fade -> cnt, cur_rgb and pwm_x frozen. On release, the fade resumes with no skipped or extra ticks.
- Gamma (RGB_PWM_FADER_GAMMA_EN defined): duty 128 -> pwm_r high 64 of 256 cycles; duty 1 -> pwm_r always low. Undefined: duty 128 -> 128 cycles high.
